// File: rtl/lu_arb_pkg.sv
// -----------------------------------------------------------------------------
// lu_arb_pkg
// Shared types and helpers for the LU stream arbiter.
//   arb_state_e : arbiter FSM state (idle / locked to one source)
//   rr_pick     : round-robin search for the first requester at or after ptr
// -----------------------------------------------------------------------------
package lu_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // rr_pick works on a fixed-width request vector; callers zero-extend.
   localparam int unsigned RR_MAX_SRC = 32;
   localparam int unsigned RR_IDX_W   = 5;

   typedef logic [RR_IDX_W:0] rr_wide_t;

   // Returns the first index k with req[k] set, searching ptr, ptr+1, ...
   // cyclically over nsrc entries. Returns ptr when nothing is requested.
   function automatic logic [RR_IDX_W-1:0] rr_pick(
      input logic [RR_MAX_SRC-1:0] req,
      input logic [RR_IDX_W-1:0]   ptr,
      input int unsigned           nsrc
   );
      rr_wide_t idx;
      logic     found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < RR_MAX_SRC; i++) begin
         // ptr < nsrc and i < nsrc, so one subtraction is a full modulo
         idx = {1'b0, ptr} + rr_wide_t'(i);
         if (idx >= rr_wide_t'(nsrc)) begin
            idx = idx - rr_wide_t'(nsrc);
         end
         if (!found && (i < int'(nsrc)) && req[idx[RR_IDX_W-1:0]]) begin
            rr_pick = idx[RR_IDX_W-1:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/stream_reg.sv
// -----------------------------------------------------------------------------
// stream_reg
// One-entry registered have/want stage. A beat is captured whenever the
// upstream offers it and the stage can take it; the stage can take a beat
// when it is empty or its current beat is leaving this cycle.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data, i_have   : upstream payload and valid
//   o_want           : upstream ready (combinational from o_have and i_want)
//   o_data, o_have   : registered payload and valid
//   i_want           : downstream ready
// -----------------------------------------------------------------------------
module stream_reg #(
   parameter int unsigned DW = 8
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic [DW-1:0] i_data,
   input  logic          i_have,
   output logic          o_want,
   output logic [DW-1:0] o_data,
   output logic          o_have,
   input  logic          i_want
);

   logic          r_have;
   logic [DW-1:0] r_data;
   logic          w_load;

   assign o_want = !r_have || i_want;
   assign w_load = i_have && o_want;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_have <= 1'b0;
         r_data <= '0;
      end else begin
         if (w_load) begin
            r_have <= 1'b1;
            r_data <= i_data;
         end else if (i_want) begin
            r_have <= 1'b0;
         end
      end
   end

   assign o_have = r_have;
   assign o_data = r_data;

endmodule

// File: rtl/lu_stream_arb.sv
// -----------------------------------------------------------------------------
// lu_stream_arb
// Packet-level round-robin arbiter merging NSRC have/want streams into one.
// A source holds the grant from its first to its last beat; a packet that
// reaches MAX_BEATS beats is cut there (o_last forced, o_overlong pulsed) and
// the source must re-arbitrate for the rest.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_in   [NSRC*WIDTH] : per-source data, source k at [k*WIDTH +: WIDTH]
//   i_last [NSRC]       : per-source end-of-packet
//   i_have [NSRC]       : per-source valid
//   o_want [NSRC]       : per-source ready (only the granted source)
//   o_out, o_last, o_src, o_have : registered merged beat
//   i_want              : downstream ready
//   o_overlong          : one-cycle pulse with a force-terminated beat
// NSRC must not exceed lu_arb_pkg::RR_MAX_SRC.
// -----------------------------------------------------------------------------
module lu_stream_arb
   import lu_arb_pkg::*;
#(
   parameter int unsigned NSRC      = 4,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_BEATS = 256,
   parameter int unsigned SRC_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [NSRC*WIDTH-1:0] i_in,
   input  logic [NSRC-1:0]       i_last,
   input  logic [NSRC-1:0]       i_have,
   output logic [NSRC-1:0]       o_want,
   output logic [WIDTH-1:0]      o_out,
   output logic                  o_last,
   output logic [SRC_W-1:0]      o_src,
   output logic                  o_have,
   input  logic                  i_want,
   output logic                  o_overlong
);

   localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);
   localparam int unsigned SLICE_W = WIDTH + 1 + SRC_W;

   arb_state_e        r_state, w_state_next;
   logic [SRC_W-1:0]  r_ptr, w_ptr_next;
   logic [SRC_W-1:0]  r_grant, w_grant_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic              r_overlong, w_overlong_next;

   logic [RR_MAX_SRC-1:0] w_req;
   logic [WIDTH-1:0]      w_sel_data;
   logic                  w_sel_last;
   logic                  w_sel_have;
   logic                  w_slice_have;
   logic                  w_slice_ready;
   logic                  w_xfer;
   logic                  w_at_max;
   logic                  w_end;
   logic                  w_forced;
   logic [SRC_W-1:0]      w_grant_inc;
   logic [SLICE_W-1:0]    w_slice_in;
   logic [SLICE_W-1:0]    w_slice_out;

   assign w_req = RR_MAX_SRC'(i_have);

   // Input mux: select the granted source's beat.
   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      w_sel_have = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (r_grant == SRC_W'(k)) begin
            w_sel_data = i_in[k*WIDTH +: WIDTH];
            w_sel_last = i_last[k];
            w_sel_have = i_have[k];
         end
      end
   end

   assign w_slice_have = (r_state == ARB_LOCKED) && w_sel_have;
   assign w_xfer       = w_slice_have && w_slice_ready;
   assign w_at_max     = (r_cnt == CNT_W'(MAX_BEATS - 1));
   assign w_end        = w_sel_last || w_at_max;
   assign w_forced     = w_at_max && !w_sel_last;
   // Wraps to 0 after the last source; with NSRC=1 this is always 0.
   assign w_grant_inc  = (r_grant == SRC_W'(NSRC - 1)) ? '0 : r_grant + SRC_W'(1);

   // Only the granted source sees ready, and only while locked; the path from
   // i_want is purely through the slice's ready term.
   always_comb begin
      o_want = '0;
      if (r_state == ARB_LOCKED) begin
         for (int k = 0; k < NSRC; k++) begin
            if (r_grant == SRC_W'(k)) begin
               o_want[k] = w_slice_ready;
            end
         end
      end
   end

   // FSM next-state and bookkeeping.
   always_comb begin
      w_state_next    = r_state;
      w_ptr_next      = r_ptr;
      w_grant_next    = r_grant;
      w_cnt_next      = r_cnt;
      w_overlong_next = 1'b0;
      unique case (r_state)
         ARB_IDLE: begin
            if (|i_have) begin
               w_grant_next = SRC_W'(rr_pick(w_req, RR_IDX_W'(r_ptr), NSRC));
               w_cnt_next   = '0;
               w_state_next = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (w_xfer) begin
               if (r_cnt != CNT_W'(MAX_BEATS)) begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
               if (w_end) begin
                  w_state_next    = ARB_IDLE;
                  w_ptr_next      = w_grant_inc;
                  w_overlong_next = w_forced;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= ARB_IDLE;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_cnt      <= '0;
         r_overlong <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_ptr      <= w_ptr_next;
         r_grant    <= w_grant_next;
         r_cnt      <= w_cnt_next;
         r_overlong <= w_overlong_next;
      end
   end

   // A forced cut is flagged as last so downstream sees a closed packet.
   assign w_slice_in = {w_sel_data, w_end, r_grant};

   stream_reg #(
      .DW (SLICE_W)
   ) u_slice (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_data    (w_slice_in),
      .i_have    (w_slice_have),
      .o_want    (w_slice_ready),
      .o_data    (w_slice_out),
      .o_have    (o_have),
      .i_want    (i_want)
   );

   assign o_out      = w_slice_out[SRC_W+1 +: WIDTH];
   assign o_last     = w_slice_out[SRC_W];
   assign o_src      = w_slice_out[SRC_W-1:0];
   assign o_overlong = r_overlong;

endmodule

// File: tb/tb_lu_stream_arb.sv
module tb_lu_stream_arb;

   localparam int NSRC  = 4;
   localparam int WIDTH = 32;
   localparam int MAXB  = 4;
   localparam int SRC_W = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NSRC*WIDTH-1:0] in_v;
   logic [NSRC-1:0]       last_v;
   logic [NSRC-1:0]       have_v;
   logic [NSRC-1:0]       o_want;
   logic [WIDTH-1:0]      o_out;
   logic                  o_last;
   logic [SRC_W-1:0]      o_src;
   logic                  o_have;
   logic                  i_want;
   logic                  o_overlong;

   lu_stream_arb #(
      .NSRC      (NSRC),
      .WIDTH     (WIDTH),
      .MAX_BEATS (MAXB)
   ) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_in       (in_v),
      .i_last     (last_v),
      .i_have     (have_v),
      .o_want     (o_want),
      .o_out      (o_out),
      .o_last     (o_last),
      .o_src      (o_src),
      .o_have     (o_have),
      .i_want     (i_want),
      .o_overlong (o_overlong)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [31:0] data; logic last; logic seg0;} beat_t;
   typedef struct packed {logic [31:0] data; logic last; logic ovl;} exp_t;

   beat_t src_q[NSRC][$];
   exp_t  exp_q[NSRC][$];
   int    segc[NSRC];
   int    vectors = 0;
   int    errors  = 0;
   int    cyc     = 0;
   int    bubble_pct = 0;
   int    stall_pct  = 0;
   bit    rand_want  = 0;
   bit    mon_en     = 0;
   logic [NSRC-1:0] in_xfer = '0;

   // monitor / model state
   bit          in_pkt = 0;
   int          cur_src = 0;
   int          model_ptr = 0;
   bit          ovl_seen = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_out;
   logic        prev_last;
   logic [1:0]  prev_src;
   int          out_cyc[$];
   int          src_log[$];

   // Stimulus generator: queues source beats and the merged beats they must
   // produce. Segments are cut after MAXB beats unless last arrives first.
   task automatic gen(input int k, input int len, input bit with_last, input logic [31:0] base);
      beat_t b;
      exp_t  e;
      bit    lin, forced;
      for (int i = 0; i < len; i++) begin
         segc[k]++;
         lin    = with_last && (i == len - 1);
         forced = (segc[k] == MAXB) && !lin;
         b.data = base + 32'(i);
         b.last = lin;
         b.seg0 = (segc[k] == 1);
         e.data = b.data;
         e.last = lin || forced;
         e.ovl  = forced;
         if (lin || forced) segc[k] = 0;
         src_q[k].push_back(b);
         exp_q[k].push_back(e);
      end
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < NSRC; k++) begin
         if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 0;
      end
      return 1;
   endfunction

   // Expected winner: first source with pending beats, cyclically from ptr.
   function automatic int rr_expect();
      for (int i = 0; i < NSRC; i++) begin
         int k;
         k = (model_ptr + i) % NSRC;
         if (exp_q[k].size() > 0) return k;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
      for (int k = 0; k < NSRC; k++) begin
         if (in_xfer[k]) begin
            src_q[k].delete(0);
            have_v[k] = 1'b0;
         end
         if (!have_v[k] && src_q[k].size() > 0) begin
            // No bubble on a segment's first beat, so it is visible at arbitration.
            if (src_q[k][0].seg0 || ($urandom_range(99) >= bubble_pct)) begin
               have_v[k]               = 1'b1;
               in_v[k*WIDTH +: WIDTH]  = src_q[k][0].data;
               last_v[k]               = src_q[k][0].last;
            end
         end
      end
      if (rand_want) i_want = ($urandom_range(99) >= stall_pct);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (!all_empty() && n < 3000) begin
         step();
         n++;
      end
      vectors++;
      if (!all_empty()) begin
         errors++;
         $display("FAIL %s_drain: data still pending after %0d cycles, required all delivered", name, n);
      end
      repeat (3) step();
   endtask

   task automatic check_rst(input string name);
      vectors++;
      if (o_have !== 1'b0 || o_want !== '0 || o_out !== '0 || o_last !== 1'b0 ||
          o_src !== '0 || o_overlong !== 1'b0) begin
         errors++;
         $display("FAIL %s: have=%b want=%b out=%h last=%b src=%0d ovl=%b, required all zero",
                  name, o_have, o_want, o_out, o_last, o_src, o_overlong);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < NSRC; k++) begin
         src_q[k].delete();
         exp_q[k].delete();
         segc[k] = 0;
      end
      have_v     = '0;
      last_v     = '0;
      in_pkt     = 0;
      model_ptr  = 0;
      ovl_seen   = 0;
      prev_stall = 0;
   endtask

   // Monitor: samples mid-cycle, pops the scoreboard on each output transfer.
   always @(negedge clk) begin
      int   s, es;
      exp_t e;
      in_xfer = have_v & o_want;
      if (mon_en) begin
         vectors++;
         if (!$onehot0(o_want)) begin
            errors++;
            $display("FAIL want_onehot: o_want=%b, required at most one bit", o_want);
         end
         if (prev_stall) begin
            vectors++;
            if (o_have !== 1'b1 || o_out !== prev_out || o_last !== prev_last || o_src !== prev_src) begin
               errors++;
               $display("FAIL hold: have=%b out=%h src=%0d, required have=1 out=%h src=%0d",
                        o_have, o_out, o_src, prev_out, prev_src);
            end
         end
         if (o_overlong) ovl_seen = 1;
         if (o_have && i_want) begin
            s = int'(o_src);
            out_cyc.push_back(cyc);
            src_log.push_back(s);
            vectors++;
            if (exp_q[s].size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: src=%0d out=%h, required no beat", s, o_out);
            end else begin
               if (!in_pkt) begin
                  es = rr_expect();
                  if (s != es) begin
                     errors++;
                     $display("FAIL rr_order: src=%0d, required src=%0d", s, es);
                  end
               end else if (s != cur_src) begin
                  errors++;
                  $display("FAIL interleave: src=%0d, required src=%0d", s, cur_src);
               end
               e = exp_q[s].pop_front();
               vectors++;
               if (o_out !== e.data || o_last !== e.last || ovl_seen !== e.ovl) begin
                  errors++;
                  $display("FAIL beat: src=%0d out=%h last=%b ovl=%b, required out=%h last=%b ovl=%b",
                           s, o_out, o_last, ovl_seen, e.data, e.last, e.ovl);
               end
               if (e.last) begin
                  in_pkt    = 0;
                  model_ptr = (s + 1) % NSRC;
               end else begin
                  in_pkt  = 1;
                  cur_src = s;
               end
            end
            ovl_seen = 0;
         end
         prev_stall = o_have && !i_want;
         prev_out   = o_out;
         prev_last  = o_last;
         prev_src   = o_src;
      end
   end

   initial begin
      int c0, n;
      rst_n  = 1'b0;
      in_v   = '0;
      last_v = '0;
      have_v = '0;
      i_want = 1'b1;
      for (int k = 0; k < NSRC; k++) segc[k] = 0;
      #1;
      check_rst("reset_state");
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1;
      step();

      // Single source: A,B,C on consecutive cycles after one idle cycle.
      out_cyc.delete();
      gen(2, 3, 1, 32'hA);
      step();
      c0 = cyc;
      #1;
      vectors++;
      if (o_want[2] !== 1'b0) begin
         errors++;
         $display("FAIL single_idle_want: o_want[2]=%b, required 0", o_want[2]);
      end
      step();
      #1;
      vectors++;
      if (o_want[2] !== 1'b1) begin
         errors++;
         $display("FAIL single_grant_want: o_want[2]=%b, required 1", o_want[2]);
      end
      drain("single");
      vectors++;
      if (out_cyc.size() != 3 || out_cyc[0] != c0 + 2 || out_cyc[2] != c0 + 4) begin
         errors++;
         $display("FAIL single_timing: beats=%0d first=%0d, required 3 beats at cycles %0d..%0d",
                  out_cyc.size(), (out_cyc.size() > 0) ? out_cyc[0] : -1, c0 + 2, c0 + 4);
      end

      // Overlong: src3 sends 6 beats without last, then a closing beat; src0 waits.
      gen(3, 6, 0, 32'h3000);
      gen(3, 1, 1, 32'h3006);
      gen(0, 1, 1, 32'h0100);
      drain("overlong");

      // No interleave: src1 requests during src0's second beat.
      gen(0, 4, 1, 32'h0200);
      n = 0;
      while (src_q[0].size() > 3 && n < 50) begin step(); n++; end
      gen(1, 2, 1, 32'h1200);
      n = 0;
      while (src_q[0].size() > 0 && n < 50) begin
         step();
         n++;
         #1;
         vectors++;
         if (o_want[1] !== 1'b0) begin
            errors++;
            $display("FAIL nointerleave_want1: o_want[1]=%b, required 0", o_want[1]);
         end
      end
      drain("nointerleave");

      // Backpressure: five stalled cycles mid-packet.
      gen(1, 5, 1, 32'h1500);
      n = 0;
      while (src_q[1].size() > 3 && n < 50) begin step(); n++; end
      i_want = 1'b0;
      repeat (5) begin
         #1;
         vectors++;
         if (o_want[1] !== 1'b0 || o_have !== 1'b1) begin
            errors++;
            $display("FAIL stall: o_want[1]=%b o_have=%b, required want 0 have 1", o_want[1], o_have);
         end
         step();
      end
      i_want = 1'b1;
      drain("backpressure");

      // Fairness: every source holds 1-beat packets.
      src_log.delete();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NSRC; k++) gen(k, 1, 1, 32'(k * 16 + r));
      end
      drain("fairness");
      vectors++;
      n = 0;
      for (int i = 1; i < src_log.size(); i++) begin
         if (src_log[i] != (src_log[0] + i) % NSRC) n++;
      end
      if (src_log.size() != 12 || n != 0) begin
         errors++;
         $display("FAIL fairness_order: beats=%0d out_of_turn=%0d, required 12 beats in rotation",
                  src_log.size(), n);
      end

      // Reset mid-packet, after src1 has moved the pointer to 2.
      gen(1, 1, 1, 32'h1900);
      drain("rst_pre");
      gen(2, 4, 1, 32'h2900);
      n = 0;
      while (src_q[2].size() > 3 && n < 50) begin step(); n++; end
      vectors++;
      if (src_q[2].size() != 3) begin
         errors++;
         $display("FAIL rst_wait: pending=%0d, required 3", src_q[2].size());
      end
      mon_en = 0;
      #1;
      rst_n = 1'b0;
      #1;
      check_rst("reset_midpacket");
      clear_model();
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1;

      // Randomized traffic with bubbles and backpressure; first pick must be src0.
      for (int k = 0; k < NSRC; k++) begin
         int np;
         np = int'($urandom_range(2, 6));
         for (int p = 0; p < np; p++) gen(k, int'($urandom_range(1, 6)), 1, $urandom);
      end
      bubble_pct = 25;
      stall_pct  = 30;
      rand_want  = 1;
      drain("random");
      rand_want = 0;
      i_want    = 1'b1;
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
